sc_output_collector: RTL and testbench

//  Downstream stage of the SC matrix-multiply core. Takes the per-element binary results
//  (one BINARY_PRECISION word per outputWrEn pulse from the sd_converter path), packs

---
 rtl/sc_output_collector.sv | 164 ++++++++++++++++
 tb/tb_sc_output_collector.sv | 394 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sc_output_collector.sv
// Packs OUTPUT_FEATURES result elements per row, buffers rows and writes them to memory via valid/ready.
// Optional build macro SC_OUTCOL_BIPOLAR_EN: convert offset-binary elements to two's complement (MSB flip).
module sc_output_collector #(
  parameter int                    BINARY_PRECISION = 8,
  parameter int                    OUTPUT_FEATURES  = 4,
  parameter int                    BATCH_SIZE       = 4,
  parameter int                    ADDR_WIDTH       = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR        = 'h4000_0000,
  parameter int                    FIFO_DEPTH       = 2
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic                                     start,
  input  logic [BINARY_PRECISION-1:0]              in_data,
  input  logic                                     in_valid,
  output logic [BINARY_PRECISION*OUTPUT_FEATURES-1:0] out_data,
  output logic [ADDR_WIDTH-1:0]                    out_addr,
  output logic                                     out_valid,
  input  logic                                     out_ready,
  output logic                                     busy,
  output logic                                     done,
  output logic                                     overflow
);

  localparam int BP    = BINARY_PRECISION;
  localparam int ROW_W = BINARY_PRECISION * OUTPUT_FEATURES;
  localparam int EW    = (OUTPUT_FEATURES > 1) ? $clog2(OUTPUT_FEATURES) : 1;
  localparam int RW    = $clog2(BATCH_SIZE + 1);
  localparam int PW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW    = $clog2(FIFO_DEPTH + 1);

  localparam logic [EW-1:0] LAST_ELEM = EW'(OUTPUT_FEATURES - 1);
  localparam logic [RW-1:0] LAST_ROW  = RW'(BATCH_SIZE - 1);
  localparam logic [PW-1:0] LAST_PTR  = PW'(FIFO_DEPTH - 1);
  localparam logic [CW-1:0] FULL_CNT  = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_COLLECT,
    S_DRAIN,
    S_DONE
  } state_e;

  state_e          state_q;
  logic [EW-1:0]   elem_idx_q;
  logic [RW-1:0]   rows_in_q;
  logic [RW-1:0]   rows_out_q;
  logic [ROW_W-1:0] row_q;
  logic [ROW_W-1:0] row_full;
  logic            busy_q;
  logic            done_q;
  logic            overflow_q;

  logic [ROW_W-1:0] mem_q [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr_q;
  logic [PW-1:0]   rd_ptr_q;
  logic [CW-1:0]   count_q;
  logic [CW-1:0]   count_d;

  logic [BP-1:0]   elem_conv;
  logic            collect_fire;
  logic            row_done;
  logic            fifo_full;
  logic            push;
  logic            pop;
  logic            drop;

`ifdef SC_OUTCOL_BIPOLAR_EN
  assign elem_conv = {~in_data[BP-1], in_data[BP-2:0]};
`else
  assign elem_conv = in_data;
`endif

  // NOTE: always_comb starts from a full default so no path leaves row_full unassigned (no latch).
  always_comb begin
    row_full = row_q;
    row_full[int'(elem_idx_q)*BP +: BP] = elem_conv;
  end

  assign collect_fire = (state_q == S_COLLECT) && in_valid;
  assign row_done     = collect_fire && (elem_idx_q == LAST_ELEM);
  assign out_valid    = (count_q != '0);
  assign pop          = out_valid && out_ready;
  assign fifo_full    = (count_q == FULL_CNT);
  // A pop on the same edge frees the slot, so a full FIFO can still take the row.
  assign push         = row_done && (!fifo_full || pop);
  assign drop         = row_done && fifo_full && !pop;
  assign count_d      = count_q + CW'(push) - CW'(pop);

  assign out_data = out_valid ? mem_q[rd_ptr_q] : '0;
  assign out_addr = BASE_ADDR + ADDR_WIDTH'(rows_out_q);
  assign busy     = busy_q;
  assign done     = done_q;
  assign overflow = overflow_q;

  // NOTE: row storage has no reset; stale entries are never visible because out_data is masked by out_valid.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= row_full;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every read sees pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      elem_idx_q <= '0;
      rows_in_q  <= '0;
      rows_out_q <= '0;
      row_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (pop) rows_out_q <= rows_out_q + 1'b1;
      if (collect_fire) begin
        row_q      <= row_full;
        elem_idx_q <= row_done ? '0 : elem_idx_q + 1'b1;
      end
      if (row_done) rows_in_q <= rows_in_q + 1'b1;
      if (drop) overflow_q <= 1'b1;

      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            overflow_q <= 1'b0;
            elem_idx_q <= '0;
            rows_in_q  <= '0;
            rows_out_q <= '0;
            busy_q     <= 1'b1;
            state_q    <= S_COLLECT;
          end
        end
        S_COLLECT: begin
          // Dropped rows still count, so the matrix always terminates.
          if (row_done && (rows_in_q == LAST_ROW)) state_q <= S_DRAIN;
        end
        S_DRAIN: begin
          if (count_d == '0) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sc_output_collector.sv
// Randomized self-checking bench for sc_output_collector against a queue-based behavioural model.
module tb_sc_output_collector;

  localparam int          OF    = 4;
  localparam int          BATCH = 4;
  localparam int          DEPTH = 2;
  localparam logic [31:0] BASE  = 32'h4000_0000;
`ifdef SC_OUTCOL_BIPOLAR_EN
  localparam bit BIPOLAR = 1'b1;
`else
  localparam bit BIPOLAR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] out_data;
  logic [31:0] out_addr;
  logic        out_valid;
  logic        busy;
  logic        done;
  logic        overflow;

  always #5 clk = ~clk;

  sc_output_collector dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .out_data  (out_data),
    .out_addr  (out_addr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy),
    .done      (done),
    .overflow  (overflow)
  );

  int n_checks = 0;
  int n_errors = 0;
  int done_cnt = 0;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } acc_t;
  acc_t obs_log[$];

  // Reference model: phase 0 idle, 1 collecting, 2 draining, 3 done.
  int          m_phase;
  logic [7:0]  m_elems[$];
  logic [31:0] m_fifo[$];
  int          m_rows_in;
  int          m_rows_out;
  bit          m_ovf;
  bit          m_done;

  function automatic logic [7:0] conv(input logic [7:0] b);
    return BIPOLAR ? (b ^ 8'h80) : b;
  endfunction

  function automatic logic [31:0] pack4(input logic [7:0] e0, input logic [7:0] e1,
                                        input logic [7:0] e2, input logic [7:0] e3);
    return {conv(e3), conv(e2), conv(e1), conv(e0)};
  endfunction

  task automatic model_reset();
    m_phase = 0;
    m_elems.delete();
    m_fifo.delete();
    m_rows_in = 0;
    m_rows_out = 0;
    m_ovf = 1'b0;
    m_done = 1'b0;
  endtask

  task automatic model_step(input bit st, input bit v, input logic [7:0] d, input bit rdy);
    bit pop;
    logic [31:0] row;
    m_done = 1'b0;
    pop = (m_fifo.size() != 0) && rdy;
    if (pop) begin
      void'(m_fifo.pop_front());
      m_rows_out++;
    end
    case (m_phase)
      0: if (st) begin
        m_ovf = 1'b0;
        m_elems.delete();
        m_rows_in = 0;
        m_rows_out = 0;
        m_phase = 1;
      end
      1: if (v) begin
        m_elems.push_back(conv(d));
        if (m_elems.size() == OF) begin
          row = 32'h0;
          for (int k = 0; k < OF; k++) row = row | (32'(m_elems[k]) << (8 * k));
          if (m_fifo.size() < DEPTH) m_fifo.push_back(row);
          else m_ovf = 1'b1;
          m_elems.delete();
          m_rows_in++;
          if (m_rows_in == BATCH) m_phase = 2;
        end
      end
      2: if (m_fifo.size() == 0) begin
        m_phase = 3;
        m_done = 1'b1;
      end
      default: m_phase = 0;
    endcase
  endtask

  // One clock: drive inputs, log accepted rows, advance the model, then compare every output.
  task automatic tick(input bit st, input bit v, input logic [7:0] d, input bit rdy);
    logic exp_v;
    logic exp_busy;
    start = st;
    in_valid = v;
    in_data = d;
    out_ready = rdy;
    if (out_valid && out_ready) obs_log.push_back('{addr: out_addr, data: out_data});
    model_step(st, v, d, rdy);
    @(posedge clk);
    #1;
    exp_v = (m_fifo.size() != 0);
    exp_busy = (m_phase == 1) || (m_phase == 2);
    n_checks++;
    if (out_valid !== exp_v) begin
      n_errors++;
      $display("FAIL out_valid @%0t: got %b expected %b", $time, out_valid, exp_v);
    end
    if (exp_v) begin
      n_checks++;
      if (out_data !== m_fifo[0]) begin
        n_errors++;
        $display("FAIL out_data @%0t: got %h expected %h", $time, out_data, m_fifo[0]);
      end
    end
    n_checks++;
    if (out_addr !== BASE + 32'(m_rows_out)) begin
      n_errors++;
      $display("FAIL out_addr @%0t: got %h expected %h", $time, out_addr, BASE + 32'(m_rows_out));
    end
    n_checks++;
    if (busy !== exp_busy) begin
      n_errors++;
      $display("FAIL busy @%0t: got %b expected %b", $time, busy, exp_busy);
    end
    n_checks++;
    if (done !== m_done) begin
      n_errors++;
      $display("FAIL done @%0t: got %b expected %b", $time, done, m_done);
    end
    n_checks++;
    if (overflow !== m_ovf) begin
      n_errors++;
      $display("FAIL overflow @%0t: got %b expected %b", $time, overflow, m_ovf);
    end
    if (done) done_cnt++;
  endtask

  task automatic wait_done(input int budget, input int ready_pct);
    bit seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      tick(1'b0, 1'b0, 8'h00, $urandom_range(0, 99) < ready_pct);
      if (done) seen = 1'b1;
    end
    n_checks++;
    if (!seen) begin
      n_errors++;
      $display("FAIL wait_done: done not seen within %0d cycles", budget);
    end
    tick(1'b0, 1'b0, 8'h00, 1'b1);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #2 rst = 1'b0;
    #1;
    model_reset();
    n_checks += 6;
    if (out_valid !== 1'b0) begin n_errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    if (out_data !== 32'h0) begin n_errors++; $display("FAIL reset_out_data: got %h expected 0", out_data); end
    if (out_addr !== BASE) begin n_errors++; $display("FAIL reset_out_addr: got %h expected %h", out_addr, BASE); end
    if (busy !== 1'b0) begin n_errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    if (done !== 1'b0) begin n_errors++; $display("FAIL reset_done: got %b expected 0", done); end
    if (overflow !== 1'b0) begin n_errors++; $display("FAIL reset_overflow: got %b expected 0", overflow); end
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
  endtask

  task automatic test_basic();
    logic [31:0] exp_data;
    obs_log.delete();
    done_cnt = 0;
    tick(1'b1, 1'b0, 8'h00, 1'b1);
    for (int i = 1; i <= 16; i++) tick(1'b0, 1'b1, 8'(i), 1'b1);
    wait_done(20, 100);
    n_checks++;
    if (obs_log.size() != 4) begin
      n_errors++;
      $display("FAIL basic_rows: got %0d accepted expected 4", obs_log.size());
    end else begin
      for (int r = 0; r < 4; r++) begin
        exp_data = pack4(8'(4*r+1), 8'(4*r+2), 8'(4*r+3), 8'(4*r+4));
        n_checks += 2;
        if (obs_log[r].data !== exp_data) begin
          n_errors++;
          $display("FAIL basic_data row%0d: got %h expected %h", r, obs_log[r].data, exp_data);
        end
        if (obs_log[r].addr !== BASE + 32'(r)) begin
          n_errors++;
          $display("FAIL basic_addr row%0d: got %h expected %h", r, obs_log[r].addr, BASE + 32'(r));
        end
      end
    end
    n_checks++;
    if (done_cnt != 1) begin
      n_errors++;
      $display("FAIL basic_done_count: got %0d expected 1", done_cnt);
    end
  endtask

  task automatic test_overflow();
    logic [7:0]  d[16];
    logic [31:0] held;
    obs_log.delete();
    held = 32'h0;
    tick(1'b1, 1'b0, 8'h00, 1'b0);
    for (int e = 0; e < 16; e++) begin
      d[e] = 8'($urandom_range(0, 255));
      tick(1'b0, 1'b1, d[e], 1'b0);
      if (e == 3) held = out_data;
      if (e == 11) begin
        n_checks += 3;
        if (overflow !== 1'b1) begin n_errors++; $display("FAIL ovf_set: got %b expected 1", overflow); end
        if (held !== pack4(d[0], d[1], d[2], d[3])) begin
          n_errors++;
          $display("FAIL ovf_row0: got %h expected %h", held, pack4(d[0], d[1], d[2], d[3]));
        end
        if (out_data !== held) begin n_errors++; $display("FAIL ovf_stable: got %h expected %h", out_data, held); end
      end
    end
    for (int i = 0; i < 5; i++) tick(1'b0, 1'b0, 8'h00, 1'b0);
    n_checks += 2;
    if (overflow !== 1'b1) begin n_errors++; $display("FAIL ovf_sticky: got %b expected 1", overflow); end
    if (out_data !== held) begin n_errors++; $display("FAIL ovf_hold: got %h expected %h", out_data, held); end
    wait_done(20, 100);
    n_checks++;
    if (obs_log.size() != 2) begin
      n_errors++;
      $display("FAIL ovf_rows: got %0d accepted expected 2", obs_log.size());
    end else begin
      n_checks += 3;
      if (obs_log[0].addr !== BASE || obs_log[1].addr !== BASE + 32'd1) begin
        n_errors++;
        $display("FAIL ovf_addrs: got %h,%h expected %h,%h", obs_log[0].addr, obs_log[1].addr, BASE, BASE + 32'd1);
      end
      if (obs_log[0].data !== held) begin
        n_errors++;
        $display("FAIL ovf_data0: got %h expected %h", obs_log[0].data, held);
      end
      if (obs_log[1].data !== pack4(d[4], d[5], d[6], d[7])) begin
        n_errors++;
        $display("FAIL ovf_data1: got %h expected %h", obs_log[1].data, pack4(d[4], d[5], d[6], d[7]));
      end
    end
    n_checks++;
    if (overflow !== 1'b1) begin n_errors++; $display("FAIL ovf_after_done: got %b expected 1", overflow); end
  endtask

  task automatic test_full_push_pop();
    obs_log.delete();
    tick(1'b1, 1'b0, 8'h00, 1'b0);
    for (int e = 0; e < 11; e++) tick(1'b0, 1'b1, 8'($urandom_range(0, 255)), 1'b0);
    tick(1'b0, 1'b1, 8'($urandom_range(0, 255)), 1'b1);
    n_checks += 2;
    if (overflow !== 1'b0) begin n_errors++; $display("FAIL pushpop_ovf: got %b expected 0", overflow); end
    if (obs_log.size() != 1) begin n_errors++; $display("FAIL pushpop_accept: got %0d expected 1", obs_log.size()); end
    for (int e = 0; e < 4; e++) tick(1'b0, 1'b1, 8'($urandom_range(0, 255)), 1'b1);
    wait_done(20, 100);
    n_checks += 2;
    if (obs_log.size() != 4) begin n_errors++; $display("FAIL pushpop_rows: got %0d expected 4", obs_log.size()); end
    if (overflow !== 1'b0) begin n_errors++; $display("FAIL pushpop_ovf_end: got %b expected 0", overflow); end
  endtask

  task automatic test_reset_mid();
    tick(1'b1, 1'b0, 8'h00, 1'b0);
    for (int e = 0; e < 6; e++) tick(1'b0, 1'b1, 8'($urandom_range(0, 255)), 1'b0);
    n_checks++;
    if (out_valid !== 1'b1) begin n_errors++; $display("FAIL midrst_pre: got %b expected 1", out_valid); end
    #3 rst = 1'b0;
    #1;
    model_reset();
    n_checks += 6;
    if (out_valid !== 1'b0) begin n_errors++; $display("FAIL midrst_out_valid: got %b expected 0", out_valid); end
    if (out_data !== 32'h0) begin n_errors++; $display("FAIL midrst_out_data: got %h expected 0", out_data); end
    if (out_addr !== BASE) begin n_errors++; $display("FAIL midrst_out_addr: got %h expected %h", out_addr, BASE); end
    if (busy !== 1'b0) begin n_errors++; $display("FAIL midrst_busy: got %b expected 0", busy); end
    if (done !== 1'b0) begin n_errors++; $display("FAIL midrst_done: got %b expected 0", done); end
    if (overflow !== 1'b0) begin n_errors++; $display("FAIL midrst_overflow: got %b expected 0", overflow); end
    @(posedge clk);
    #1 rst = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick(1'b0, 1'b1, 8'($urandom_range(0, 255)), 1'b1);
      n_checks++;
      if (out_valid !== 1'b0) begin n_errors++; $display("FAIL midrst_no_start: got %b expected 0", out_valid); end
    end
  endtask

  task automatic test_ignored();
    logic [7:0]  d[16];
    logic [31:0] exp_data;
    obs_log.delete();
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b1, 8'($urandom_range(0, 255)), 1'b1);
    n_checks += 2;
    if (out_valid !== 1'b0) begin n_errors++; $display("FAIL idle_valid: got %b expected 0", out_valid); end
    if (busy !== 1'b0) begin n_errors++; $display("FAIL idle_busy: got %b expected 0", busy); end
    tick(1'b1, 1'b0, 8'h00, 1'b1);
    for (int e = 0; e < 16; e++) begin
      d[e] = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 2) == 0) tick(1'b0, 1'b0, 8'($urandom_range(0, 255)), 1'b1);
      tick(e == 5 || e == 9, 1'b1, d[e], 1'b1);
    end
    wait_done(20, 100);
    n_checks++;
    if (obs_log.size() != 4) begin
      n_errors++;
      $display("FAIL ignored_rows: got %0d expected 4", obs_log.size());
    end else begin
      for (int r = 0; r < 4; r++) begin
        exp_data = pack4(d[4*r], d[4*r+1], d[4*r+2], d[4*r+3]);
        n_checks++;
        if (obs_log[r].data !== exp_data || obs_log[r].addr !== BASE + 32'(r)) begin
          n_errors++;
          $display("FAIL ignored_row%0d: got %h@%h expected %h@%h", r, obs_log[r].data, obs_log[r].addr,
                   exp_data, BASE + 32'(r));
        end
      end
    end
  endtask

  task automatic test_conversion();
    logic [7:0]  pat[4];
    logic [31:0] exp_row;
    pat[0] = 8'h80; pat[1] = 8'h00; pat[2] = 8'h7F; pat[3] = 8'hFF;
    exp_row = BIPOLAR ? 32'h7FFF_8000 : 32'hFF7F_0080;
    obs_log.delete();
    tick(1'b1, 1'b0, 8'h00, 1'b1);
    for (int e = 0; e < 16; e++) tick(1'b0, 1'b1, (e < 4) ? pat[e] : 8'($urandom_range(0, 255)), 1'b1);
    wait_done(20, 100);
    n_checks++;
    if (obs_log.size() == 0 || obs_log[0].data !== exp_row) begin
      n_errors++;
      $display("FAIL conversion: got %h expected %h", (obs_log.size() == 0) ? 32'h0 : obs_log[0].data, exp_row);
    end
  endtask

  task automatic test_random();
    for (int m = 0; m < 4; m++) begin
      tick(1'b1, 1'b0, 8'h00, 1'b1);
      for (int i = 0; i < 200 && m_phase == 1; i++)
        tick(1'b0, $urandom_range(0, 2) != 0, 8'($urandom_range(0, 255)), $urandom_range(0, 3) != 0);
      n_checks++;
      if (m_phase == 1) begin
        n_errors++;
        $display("FAIL random_collect: matrix %0d still collecting after budget", m);
      end
      wait_done(60, 70);
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_basic();
    test_overflow();
    test_full_push_pop();
    test_reset_mid();
    test_ignored();
    test_conversion();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
